// File: rtl/id_ex_elastic_reg_pkg.sv
// Shared field widths, control-bit layout and pack/unpack helpers for the ID->EX register.
package id_ex_pkg;

  localparam int EX_W   = 3;
  localparam int MEM_W  = 3;
  localparam int WB_W   = 2;
  localparam int CTRL_W = EX_W + MEM_W + WB_W;

  // Bit positions inside the packed control word {aluop[1:0], alusrc, memread, memwrite, branch, memtoreg, regwrite}
  localparam int ALUOP_HI = 7;
  localparam int ALUOP_LO = 6;
  localparam int ALUSRC   = 5;
  localparam int MEMREAD  = 4;
  localparam int MEMWRITE = 3;
  localparam int BRANCH   = 2;
  localparam int MEMTOREG = 1;
  localparam int REGWRITE = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_NOP = 8'h00;

  function automatic ctrl_t ctrl_pack(input logic [EX_W-1:0] ex, input logic [MEM_W-1:0] mem,
                                      input logic [WB_W-1:0] wb);
    return {ex, mem, wb};
  endfunction

  function automatic logic [EX_W-1:0] ctrl_ex(input ctrl_t c);
    return {c[ALUOP_HI:ALUOP_LO], c[ALUSRC]};
  endfunction

  function automatic logic [MEM_W-1:0] ctrl_mem(input ctrl_t c);
    return {c[MEMREAD], c[MEMWRITE], c[BRANCH]};
  endfunction

  function automatic logic [WB_W-1:0] ctrl_wb(input ctrl_t c);
    return {c[MEMTOREG], c[REGWRITE]};
  endfunction

endpackage

// File: rtl/id_ex_elastic_reg_if.sv
// Decode-side and execute-side handshake plus payload bundle of the ID->EX register.
interface id_ex_elastic_reg_if
  import id_ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              hazard_stall;
  logic              flush;
  logic [XLEN-1:0]   in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [EX_W-1:0]   in_ex;
  logic [MEM_W-1:0]  in_mem;
  logic [WB_W-1:0]   in_wb;
  logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
  logic [ALUC_W-1:0] in_aluc;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [EX_W-1:0]   out_ex;
  logic [MEM_W-1:0]  out_mem;
  logic [WB_W-1:0]   out_wb;
  logic [REG_AW-1:0] out_rs1, out_rs2, out_rd;
  logic [ALUC_W-1:0] out_aluc;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  in_valid, hazard_stall, flush, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_ex, in_mem, in_wb, in_rs1, in_rs2, in_rd, in_aluc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_ex, out_mem, out_wb, out_rs1, out_rs2, out_rd, out_aluc, bubble_cnt
  );

  modport master (
    output in_valid, hazard_stall, flush, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_ex, in_mem, in_wb, in_rs1, in_rs2, in_rd, in_aluc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_ex, out_mem, out_wb, out_rs1, out_rs2, out_rd, out_aluc, bubble_cnt
  );

endinterface

// File: rtl/id_ex_elastic_reg_skid.sv
// Generic valid/ready register: one main entry plus an optional skid entry, with flush.
module pipe_skid_reg #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_r, skid_valid_r, live_r;
  logic [W-1:0] main_data_r, skid_data_r;
  logic         main_load_s, can_take_s, accept_s;

  // Acceptance: live_r keeps in_ready low until the first clock after reset release
  always_comb begin
    main_load_s = ~main_valid_r | out_ready;
    can_take_s  = 1'b0;
    if (SKID_EN) begin
      can_take_s = ~skid_valid_r;
    end else begin
      can_take_s = main_load_s;
    end
    in_ready = live_r & can_take_s & ~stall & ~flush;
    accept_s = in_valid & in_ready;
  end

  // Entry state: the skid entry always drains into main before new input is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      live_r       <= 1'b0;
      main_data_r  <= '0;
      skid_data_r  <= '0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      live_r       <= 1'b1;
    end else begin
      live_r <= 1'b1;
      if (main_load_s) begin
        if (skid_valid_r) begin
          main_data_r  <= skid_data_r;
          main_valid_r <= 1'b1;
          skid_valid_r <= 1'b0;
        end else if (accept_s) begin
          main_data_r  <= in_data;
          main_valid_r <= 1'b1;
        end else begin
          main_valid_r <= 1'b0;
        end
      end else if (accept_s) begin
        skid_data_r  <= in_data;
        skid_valid_r <= 1'b1;
      end
    end
  end

  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;

endmodule

// File: rtl/id_ex_elastic_reg.sv
// ID->EX pipeline register: skid register on the packed payload, NOP gating of control
// fields while empty, and a saturating count of hazard-blocked requests.
module id_ex_elastic_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUC_W  = 4,
  parameter int CNT_W   = 16,
  parameter bit SKID_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  id_ex_elastic_reg_if.slave bus
);

  localparam int W = 4 * XLEN + 3 * REG_AW + ALUC_W + CTRL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [W-1:0]     in_pack_s, out_pack_s;
  logic             out_valid_s;
  ctrl_t            out_ctrl_s, ctrl_gated_s;
  logic [CNT_W-1:0] bubble_cnt_r;

  assign in_pack_s = {bus.in_pc, bus.in_rs1_data, bus.in_rs2_data, bus.in_imm,
                      bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_aluc,
                      ctrl_pack(bus.in_ex, bus.in_mem, bus.in_wb)};

  pipe_skid_reg #(.W(W), .SKID_EN(SKID_EN)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .stall    (bus.hazard_stall),
    .in_valid (bus.in_valid),
    .in_data  (in_pack_s),
    .in_ready (bus.in_ready),
    .out_valid(out_valid_s),
    .out_ready(bus.out_ready),
    .out_data (out_pack_s)
  );

  assign {bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_imm,
          bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_aluc, out_ctrl_s} = out_pack_s;

  // An empty stage must look like a NOP to execute, so control is forced to zero
  always_comb begin
    ctrl_gated_s = CTRL_NOP;
    if (out_valid_s) begin
      ctrl_gated_s = out_ctrl_s;
    end else begin
      ctrl_gated_s = CTRL_NOP;
    end
  end

  assign bus.out_valid = out_valid_s;
  assign bus.out_ex    = ctrl_ex(ctrl_gated_s);
  assign bus.out_mem   = ctrl_mem(ctrl_gated_s);
  assign bus.out_wb    = ctrl_wb(ctrl_gated_s);

  // Bubble counter: a flush in the same cycle overrides the stall and is not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= '0;
    end else if (bus.hazard_stall & bus.in_valid & ~bus.flush & (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Bench for id_ex_elastic_reg: directed scenarios plus random traffic on two configurations,
// each compared every cycle against a queue-based model of the stage.
module tb_id_ex_elastic_reg;

  typedef struct packed {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluc;
    logic [2:0]  ex, mem;
    logic [1:0]  wb;
  } ent_t;

  // Model: up to two queued entries (head = what execute sees), last head kept for data hold
  typedef struct packed {
    ent_t [1:0]  e;
    int          n;
    ent_t        last;
    int unsigned bub;
    bit          live;
  } model_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  ent_t   din = '0;
  bit     in_valid = 1'b0, out_ready = 1'b0, hazard = 1'b0, flush = 1'b0;
  model_t ma = '0, mb = '0;
  int     n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  id_ex_elastic_reg_if #(.CNT_W(16)) ifa ();
  id_ex_elastic_reg_if #(.CNT_W(2))  ifb ();

  id_ex_elastic_reg #(.CNT_W(16), .SKID_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  id_ex_elastic_reg #(.CNT_W(2),  .SKID_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  assign {ifa.in_valid, ifa.hazard_stall, ifa.flush, ifa.out_ready} = {in_valid, hazard, flush, out_ready};
  assign {ifb.in_valid, ifb.hazard_stall, ifb.flush, ifb.out_ready} = {in_valid, hazard, flush, out_ready};
  assign {ifa.in_pc, ifa.in_rs1_data, ifa.in_rs2_data, ifa.in_imm, ifa.in_rs1, ifa.in_rs2,
          ifa.in_rd, ifa.in_aluc, ifa.in_ex, ifa.in_mem, ifa.in_wb} = din;
  assign {ifb.in_pc, ifb.in_rs1_data, ifb.in_rs2_data, ifb.in_imm, ifb.in_rs1, ifb.in_rs2,
          ifb.in_rd, ifb.in_aluc, ifb.in_ex, ifb.in_mem, ifb.in_wb} = din;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_ready(input model_t m, input bit skid_en);
    if (!m.live || hazard || flush) return 1'b0;
    if (skid_en) return m.n < 2;
    return (m.n == 0) || out_ready;
  endfunction

  function automatic void model_step(inout model_t m, input bit skid_en, input int unsigned cmax);
    bit rdy;
    rdy = model_ready(m, skid_en);
    if (in_valid && hazard && !flush && m.bub < cmax) m.bub = m.bub + 1;
    if (flush) begin
      m.n = 0;
    end else begin
      if (m.n > 0 && out_ready) begin
        m.e[0] = m.e[1];
        m.n = m.n - 1;
      end
      if (in_valid && rdy) begin
        m.e[m.n] = din;
        m.n = m.n + 1;
      end
    end
    if (m.n > 0) m.last = m.e[0];
    m.live = 1'b1;
  endfunction

  task automatic check_dut(input string tag, input model_t m, input bit skid_en,
                           input logic rdy, input logic vld, input logic [7:0] ctrl,
                           input logic [146:0] data, input logic [31:0] bub);
    ent_t h;
    h = m.last;
    chk({tag, "_in_ready"}, rdy, model_ready(m, skid_en));
    chk({tag, "_out_valid"}, vld, m.n > 0);
    chk({tag, "_ctrl"}, ctrl, (m.n > 0) ? {h.ex, h.mem, h.wb} : 8'h00);
    chk({tag, "_data"}, data, {h.pc, h.rs1_data, h.rs2_data, h.imm, h.rs1, h.rs2, h.rd, h.aluc});
    chk({tag, "_bubble_cnt"}, bub, m.bub);
  endtask

  // Let combinational outputs settle after the input change, then compare both DUTs
  task automatic settle();
    #1;
    if (rst) begin
      ma = '0;
      mb = '0;
    end
    check_dut("a", ma, 1'b1, ifa.in_ready, ifa.out_valid, {ifa.out_ex, ifa.out_mem, ifa.out_wb},
              {ifa.out_pc, ifa.out_rs1_data, ifa.out_rs2_data, ifa.out_imm, ifa.out_rs1,
               ifa.out_rs2, ifa.out_rd, ifa.out_aluc}, 32'(ifa.bubble_cnt));
    check_dut("b", mb, 1'b0, ifb.in_ready, ifb.out_valid, {ifb.out_ex, ifb.out_mem, ifb.out_wb},
              {ifb.out_pc, ifb.out_rs1_data, ifb.out_rs2_data, ifb.out_imm, ifb.out_rs1,
               ifb.out_rs2, ifb.out_rd, ifb.out_aluc}, 32'(ifb.bubble_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ma = '0;
      mb = '0;
    end else begin
      model_step(ma, 1'b1, 32'd65535);
      model_step(mb, 1'b0, 32'd3);
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] pc);
    din.pc       = pc;
    din.rs1_data = pc + 32'h100;
    din.rs2_data = ~pc;
    din.imm      = pc << 1;
    din.rs1      = pc[6:2];
    din.rs2      = pc[6:2] + 5'd1;
    din.rd       = pc[6:2] ^ 5'h1f;
    din.aluc     = pc[5:2];
    din.ex       = 3'b101;
    din.mem      = 3'b010;
    din.wb       = 2'b11;
  endtask

  initial begin
    logic [159:0] r;
    @(negedge clk);
    settle(); tick();
    chk("reset_in_ready_low", ifa.in_ready, 1'b0);
    rst = 1'b0;
    settle(); tick();
    settle();
    chk("post_reset_in_ready", ifa.in_ready, 1'b1);

    // Stream
    out_ready = 1'b1; in_valid = 1'b1; set_in(32'h00);
    settle(); tick();
    set_in(32'h04); settle();
    chk("stream_pc0", {ifa.out_valid, ifa.out_pc}, {1'b1, 32'h00}); tick();
    set_in(32'h08); settle();
    chk("stream_pc4", ifa.out_pc, 32'h04); tick();
    in_valid = 1'b0; settle();
    chk("stream_pc8", ifa.out_pc, 32'h08); tick();
    settle(); tick();

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; set_in(32'h00);
    settle(); chk("bp_rdy0", ifa.in_ready, 1'b1); tick();
    set_in(32'h04); settle(); chk("bp_rdy1", ifa.in_ready, 1'b1); tick();
    set_in(32'h08); settle(); chk("bp_rdy2_full", ifa.in_ready, 1'b0); tick();
    out_ready = 1'b1; settle();
    chk("bp_out0", ifa.out_pc, 32'h00); tick();
    settle(); chk("bp_out4", ifa.out_pc, 32'h04); chk("bp_rdy_again", ifa.in_ready, 1'b1); tick();
    in_valid = 1'b0; settle(); chk("bp_out8", {ifa.out_valid, ifa.out_pc}, {1'b1, 32'h08}); tick();
    settle(); tick();

    // Hazard bubble and counter saturation
    in_valid = 1'b1; set_in(32'h20); settle(); tick();
    hazard = 1'b1; set_in(32'h24); settle();
    chk("hz_in_ready", ifa.in_ready, 1'b0); tick();
    hazard = 1'b0; in_valid = 1'b0; settle();
    chk("hz_bubble", {ifa.out_valid, ifa.out_wb, ifa.bubble_cnt}, {1'b0, 2'b00, 16'd1}); tick();
    hazard = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle(); tick();
    end
    hazard = 1'b0; in_valid = 1'b0; settle();
    chk("sat_cnt2", ifb.bubble_cnt, 2'd3);
    chk("cnt16_six", ifa.bubble_cnt, 16'd6); tick();

    // Flush with both entries full, stall asserted too
    out_ready = 1'b0; in_valid = 1'b1; set_in(32'h40); settle(); tick();
    set_in(32'h44); settle(); tick();
    flush = 1'b1; hazard = 1'b1; set_in(32'h48); settle();
    chk("fl_in_ready", ifa.in_ready, 1'b0); tick();
    flush = 1'b0; hazard = 1'b0; in_valid = 1'b0; out_ready = 1'b1; settle();
    chk("fl_empty", {ifa.out_valid, ifa.out_ex, ifa.in_ready, ifa.bubble_cnt}, {1'b0, 3'b000, 1'b1, 16'd6});
    tick();
    settle(); chk("fl_no_ghost", ifa.out_valid, 1'b0); tick();

    // Single-entry configuration: in_ready follows out_ready combinationally
    out_ready = 1'b0; in_valid = 1'b1; set_in(32'h60); settle(); tick();
    settle(); chk("noskid_rdy_low", ifb.in_ready, 1'b0);
    out_ready = 1'b1; settle(); chk("noskid_rdy_high", ifb.in_ready, 1'b1); tick();

    // Asynchronous reset with entries held
    out_ready = 1'b0; set_in(32'h80); settle(); tick();
    set_in(32'h84); settle(); tick();
    rst = 1'b1; settle();
    chk("rst_mid", {ifa.out_valid, ifa.out_ex, ifa.out_mem, ifa.out_wb, ifa.bubble_cnt, ifa.in_ready},
        {1'b0, 3'b000, 3'b000, 2'b00, 16'd0, 1'b0});
    tick();
    rst = 1'b0; in_valid = 1'b0; settle(); tick();
    settle(); chk("rst_release_rdy", ifa.in_ready, 1'b1); tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      din       = r[154:0];
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      hazard    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      settle(); tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
